// File: rtl/native_split_timeout.sv
// Routes native-bus transactions to one of N slaves by address MSBs. A watchdog
// completes any transaction a slave fails to finish with error data.
module native_split_timeout #(
    parameter int N_SLAVES   = 4,
    parameter int SEL_BITS   = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT    = 1024,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [ADDR_WIDTH-1:0]          s_addr,
    input  logic [DATA_WIDTH-1:0]          s_wdata,
    input  logic [STRB_WIDTH-1:0]          s_wstrb,
    output logic [DATA_WIDTH-1:0]          s_rdata,
    output logic [N_SLAVES-1:0]            m_valid,
    input  logic [N_SLAVES-1:0]            m_ready,
    output logic [ADDR_WIDTH-SEL_BITS-1:0] m_addr,
    output logic [DATA_WIDTH-1:0]          m_wdata,
    output logic [STRB_WIDTH-1:0]          m_wstrb,
    input  logic [N_SLAVES*DATA_WIDTH-1:0] m_rdata,
    input  logic                           err_clr,
    output logic                           err_timeout,
    output logic                           err_decode
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DERR = 2'd2;
    localparam logic [1:0] GAP  = 2'd3;

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    logic [1:0]            state;
    logic [SEL_BITS-1:0]   sel_reg;
    logic [CNT_W-1:0]      cnt;
    logic [SEL_BITS-1:0]   sel_in;
    logic                  sel_hit;
    logic                  sel_ready;
    logic [DATA_WIDTH-1:0] sel_rdata;
    logic                  timeout_hit;

    assign sel_in  = s_addr[ADDR_WIDTH-1 -: SEL_BITS];
    assign sel_hit = ({1'b0, sel_in} < (SEL_BITS + 1)'(N_SLAVES));

    // Only the routed slave's ready/rdata are visible; other slaves are ignored.
    always_comb begin
        m_valid   = '0;
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (state == BUSY && sel_reg == SEL_BITS'(i)) begin
                m_valid[i] = 1'b1;
                sel_ready  = m_ready[i];
                sel_rdata  = m_rdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign timeout_hit = (state == BUSY) && !sel_ready && (cnt == CNT_MAX);
    assign s_ready     = ((state == BUSY) && (sel_ready || timeout_hit)) || (state == DERR);

    always_comb begin
        s_rdata = '0;
        if (state == BUSY && sel_ready)
            s_rdata = sel_rdata;
        else if (timeout_hit || state == DERR)
            s_rdata = ERR_DATA;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sel_reg     <= '0;
            cnt         <= '0;
            m_addr      <= '0;
            m_wdata     <= '0;
            m_wstrb     <= '0;
            err_timeout <= 1'b0;
            err_decode  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_valid) begin
                        if (sel_hit) begin
                            state   <= BUSY;
                            sel_reg <= sel_in;
                            m_addr  <= s_addr[ADDR_WIDTH-SEL_BITS-1:0];
                            m_wdata <= s_wdata;
                            m_wstrb <= s_wstrb;
                            cnt     <= '0;
                        end else begin
                            state <= DERR;
                        end
                    end
                end
                BUSY: begin
                    if (s_ready)
                        state <= GAP;
                    else if (cnt != CNT_MAX)
                        cnt <= cnt + CNT_W'(1);
                end
                DERR:    state <= GAP;
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
            // A set event in the same cycle as err_clr keeps the flag high.
            err_timeout <= timeout_hit || (err_timeout && !err_clr);
            err_decode  <= (state == DERR) || (err_decode && !err_clr);
        end
    end

endmodule

// File: tb/tb_native_split_timeout.sv
// Randomized bench for native_split_timeout against a transaction-level model
// (route, latency, returned data and sticky flags derived from the address and slave delay).
module tb_native_split_timeout;

    localparam int N  = 3;
    localparam int SB = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 8;
    localparam logic [DW-1:0] ERR = 32'hDEADBEEF;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid;
    logic              s_ready;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_wdata;
    logic [SW-1:0]     s_wstrb;
    logic [DW-1:0]     s_rdata;
    logic [N-1:0]      m_valid;
    logic [N-1:0]      m_ready;
    logic [AW-SB-1:0]  m_addr;
    logic [DW-1:0]     m_wdata;
    logic [SW-1:0]     m_wstrb;
    logic [N*DW-1:0]   m_rdata;
    logic              err_clr;
    logic              err_timeout;
    logic              err_decode;

    native_split_timeout #(
        .N_SLAVES(N), .SEL_BITS(SB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .STRB_WIDTH(SW), .TIMEOUT(TO), .ERR_DATA(ERR)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_rdata(s_rdata),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_rdata(m_rdata),
        .err_clr(err_clr), .err_timeout(err_timeout), .err_decode(err_decode)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic exp_to;
    logic exp_de;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction: IDLE sample cycle, lat+1 routed cycles, then the GAP cycle.
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input int delay,
                           input logic [31:0] rdata, input bit stray,
                           input bit clr_done, input bit clr_gap);
        int sel;
        int lat;
        bit hit;
        bit tmo;
        logic [31:0] exp_data;
        logic [N-1:0] exp_mv;
        sel      = int'(addr[31:30]);
        hit      = sel < N;
        tmo      = hit && (delay > TO - 1);
        lat      = !hit ? 0 : (tmo ? TO - 1 : delay);
        exp_data = (hit && !tmo) ? rdata : ERR;
        exp_mv   = hit ? N'(1 << sel) : '0;

        @(negedge clk);
        s_valid = 1'b1; s_addr = addr; s_wdata = wdata; s_wstrb = wstrb; err_clr = 1'b0;
        #1;
        check("idle_s_ready", 64'(s_ready), 64'(0));
        check("idle_m_valid", 64'(m_valid), 64'(0));
        check("idle_err_timeout", 64'(err_timeout), 64'(exp_to));
        check("idle_err_decode", 64'(err_decode), 64'(exp_de));

        for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) m_rdata[i*DW +: DW] = $urandom;
            m_ready = stray ? N'($urandom) : '0;
            if (hit) begin
                m_ready[sel] = (k == delay);
                m_rdata[sel*DW +: DW] = rdata;
            end
            err_clr = (k == lat) && clr_done;
            #1;
            check("m_valid", 64'(m_valid), 64'(exp_mv));
            if (hit) begin
                check("m_addr", 64'(m_addr), 64'(addr[29:0]));
                check("m_wdata", 64'(m_wdata), 64'(wdata));
                check("m_wstrb", 64'(m_wstrb), 64'(wstrb));
            end
            check("s_ready", 64'(s_ready), 64'(k == lat));
            check("s_rdata", 64'(s_rdata), (k == lat) ? 64'(exp_data) : 64'(0));
        end
        if (tmo) exp_to = 1'b1; else if (clr_done) exp_to = 1'b0;
        if (!hit) exp_de = 1'b1; else if (clr_done) exp_de = 1'b0;

        @(negedge clk);
        s_valid = 1'b0;
        err_clr = clr_gap;
        m_ready = '0;
        if (tmo) m_ready[sel] = 1'b1;  // late ready from the timed-out slave
        #1;
        check("gap_s_ready", 64'(s_ready), 64'(0));
        check("gap_s_rdata", 64'(s_rdata), 64'(0));
        check("gap_m_valid", 64'(m_valid), 64'(0));
        check("gap_err_timeout", 64'(err_timeout), 64'(exp_to));
        check("gap_err_decode", 64'(err_decode), 64'(exp_de));
        if (clr_gap) begin exp_to = 1'b0; exp_de = 1'b0; end
    endtask

    task automatic reset_busy(input logic [31:0] addr);
        @(negedge clk);
        s_valid = 1'b1; s_addr = addr; s_wdata = $urandom; s_wstrb = 4'hF;
        err_clr = 1'b0; m_ready = '0;
        @(negedge clk);
        #1;
        check("rb_m_valid_busy", 64'(m_valid), 64'(N'(1 << addr[31:30])));
        rst = 1'b1; s_valid = 1'b0;
        @(negedge clk);
        #1;
        check("rb_m_valid", 64'(m_valid), 64'(0));
        check("rb_s_ready", 64'(s_ready), 64'(0));
        check("rb_s_rdata", 64'(s_rdata), 64'(0));
        check("rb_m_addr", 64'(m_addr), 64'(0));
        check("rb_err_timeout", 64'(err_timeout), 64'(0));
        check("rb_err_decode", 64'(err_decode), 64'(0));
        rst = 1'b0;
        exp_to = 1'b0; exp_de = 1'b0;
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_addr = '0; s_wdata = '0; s_wstrb = '0;
        m_ready = '0; m_rdata = '0; err_clr = 1'b0;
        exp_to = 1'b0; exp_de = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_m_valid", 64'(m_valid), 64'(0));
        check("rst_s_ready", 64'(s_ready), 64'(0));
        check("rst_s_rdata", 64'(s_rdata), 64'(0));
        check("rst_m_addr", 64'(m_addr), 64'(0));
        check("rst_m_wdata", 64'(m_wdata), 64'(0));
        check("rst_m_wstrb", 64'(m_wstrb), 64'(0));
        check("rst_err_timeout", 64'(err_timeout), 64'(0));
        check("rst_err_decode", 64'(err_decode), 64'(0));
        rst = 1'b0;

        run_txn(32'h8000_0010, 32'h0, 4'b0000, 3, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        run_txn(32'h0000_0040, 32'hA5A5_A5A5, 4'b0011, 0, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0);
        run_txn(32'h4000_0020, 32'h0, 4'b0000, 1000, 32'h5555_AAAA, 1'b0, 1'b0, 1'b0);
        run_txn(32'hC000_0000, 32'h1111_2222, 4'b1111, 0, 32'h0, 1'b0, 1'b0, 1'b1);
        run_txn(32'h0000_0100, 32'h0, 4'b0000, 4, 32'hCAFE_0001, 1'b1, 1'b0, 1'b0);
        run_txn(32'h4000_0004, 32'h0, 4'b0000, 1000, 32'h0, 1'b0, 1'b0, 1'b0);
        run_txn(32'hC000_0008, 32'h0, 4'b0000, 0, 32'h0, 1'b0, 1'b0, 1'b0);
        reset_busy(32'h4000_0030);
        run_txn(32'h4000_0030, 32'h0, 4'b0000, 1000, 32'h0, 1'b0, 1'b0, 1'b0);
        run_txn(32'h8000_0044, 32'h0, 4'b0000, 7, 32'h7777_0007, 1'b1, 1'b1, 1'b0);

        for (int t = 0; t < 60; t++) begin
            logic [1:0]  sel;
            logic [31:0] addr;
            sel  = 2'($urandom_range(0, 3));
            addr = {sel, 30'($urandom)};
            run_txn(addr, $urandom, 4'($urandom), int'($urandom_range(0, TO + 2)), $urandom,
                    bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/native_split_timeout.md
Name: native_split_timeout

Overview:
- 1-to-N native-bus splitter, downstream of the AXI-Lite-to-native adapter; consumes its native_valid/ready/addr/wdata/wstrb/rdata transactions.
- Decodes the top address bits and forwards each transaction to one of N native slaves (RAM, peripherals).
- Holds the route until completion.
- A watchdog completes hung transactions with error data, so a dead slave cannot lock the AXI-Lite side.

Parameters:
- N_SLAVES, 4, number of downstream native slaves (1..2**SEL_BITS)
- SEL_BITS, 2, address MSBs used as slave index
- ADDR_WIDTH, 32, upstream address width
- DATA_WIDTH, 32, data width
- STRB_WIDTH, DATA_WIDTH/8, write-strobe width
- TIMEOUT, 1024, cycles in BUSY before forced completion (>=2)
- ERR_DATA, 32'hDEADBEEF, rdata returned on timeout or decode miss (DATA_WIDTH bits)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- s_valid  in  1  upstream request, held until s_ready
- s_ready  out  1  one-cycle completion pulse
- s_addr  in  ADDR_WIDTH  request address
- s_wdata  in  DATA_WIDTH  write data
- s_wstrb  in  STRB_WIDTH  byte enables; nonzero = write, zero = read
- s_rdata  out  DATA_WIDTH  read data, valid only while s_ready=1
- m_valid  out  N_SLAVES  per-slave request, one-hot or zero
- m_ready  in  N_SLAVES  per-slave completion
- m_addr  out  ADDR_WIDTH-SEL_BITS  s_addr with select bits stripped, shared by all slaves
- m_wdata  out  DATA_WIDTH  shared write data
- m_wstrb  out  STRB_WIDTH  shared strobes
- m_rdata  in  N_SLAVES*DATA_WIDTH  slave i read data at bits [i*DATA_WIDTH +: DATA_WIDTH]
- err_clr  in  1  clears sticky error flags
- err_timeout  out  1  sticky, set on watchdog expiry
- err_decode  out  1  sticky, set on index >= N_SLAVES

Behaviour:
- States: IDLE, BUSY, DERR, GAP. Reset forces IDLE.
- Reset values: m_valid=0, s_ready=0, s_rdata=0, counter=0, err flags=0, m_addr/m_wdata/m_wstrb=0.
- IDLE, s_valid=1: sel = s_addr[ADDR_WIDTH-1 -: SEL_BITS].
  - sel < N_SLAVES: register sel_reg, m_addr, m_wdata, m_wstrb; counter=0; next BUSY.
  - sel >= N_SLAVES: next DERR.
- BUSY:
  - m_valid[sel_reg]=1, all other bits 0.
  - Registered request: first m_valid one cycle after s_valid is sampled in IDLE.
  - m_ready[sel_reg]=1: same cycle s_ready=1 and s_rdata = m_rdata slice sel_reg (combinational); next GAP.
  - m_ready bits of unselected slaves are ignored.
  - Counter increments each BUSY cycle without completion.
  - Counter = TIMEOUT-1 and m_ready[sel_reg]=0: s_ready=1, s_rdata=ERR_DATA, err_timeout<=1; next GAP.
  - Counter saturates; it never wraps.
- DERR: s_ready=1 for one cycle, s_rdata=ERR_DATA, err_decode<=1, no m_valid; writes are dropped; next GAP.
- GAP: one cycle; s_valid and all m_ready are ignored, so the upstream can drop valid; next IDLE.
- Late m_ready from a timed-out slave, arriving in GAP/IDLE, is ignored and never produces s_ready.
- s_rdata = 0 whenever s_ready=0.
- Min latency, s_valid to s_ready: 2 cycles (slave ready in first BUSY cycle). Back-to-back throughput: one transaction per 3 cycles.
- Sticky flags: err_clr clears in the cycle after assertion. A set event in the same cycle as err_clr wins (flag stays 1).
- Reset mid-BUSY: m_valid drops next edge; the in-flight transaction is abandoned with no s_ready.
- m_addr/m_wdata/m_wstrb hold the last captured value outside BUSY.

Test Plan:
- Read slave 2: s_addr=0x8000_0010, wstrb=0; slave 2 ready 3 cycles after m_valid with rdata 0x1234_5678 -> m_valid=4'b0100, m_addr=0x0000_0010, s_ready pulse carrying 0x1234_5678, then GAP, then IDLE.
- Write slave 0: wdata 0xA5A5_A5A5, wstrb 4'b0011, immediate ready -> s_ready 2 cycles after s_valid; m_wstrb=0011; no other m_valid bit ever set.
- Timeout, TIMEOUT=8: slave 1 never ready -> s_ready exactly 8 BUSY cycles in, s_rdata=0xDEADBEEF, err_timeout=1; later m_ready[1] pulse -> no s_ready.
- Decode miss, N_SLAVES=3: addr 0xC000_0000 -> m_valid stays 0, s_ready 1 cycle after sampling with 0xDEADBEEF, err_decode=1; err_clr -> 0.
- Stray ready: m_ready[3] asserted while routed to slave 0 -> ignored; completion only on m_ready[0].
- Reset while BUSY -> m_valid=0, counter=0, flags=0 next cycle; a new read then completes normally.
